// File: rtl/add_arb.sv
// Round-robin arbiter feeding one registered adder: out = low N bits of the winner's operand + PASSDOWN.
// Define ADD_ARB_STATS_EN to add grant_cnt, a saturating count of out_valid & out_ready handshakes.
module add_arb #(
  parameter int          NREQ     = 4,
  parameter int          N        = 16,
  parameter logic [31:0] PASSDOWN = 32'd1,
  localparam int         IDW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*32-1:0] in,
  output logic [NREQ-1:0]    gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out,
  output logic [IDW-1:0]     out_id
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt
`endif
);

  localparam int          SW        = IDW + 1;
  localparam logic [31:0] SLICE_MSK = 32'((64'd1 << N) - 64'd1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]       out_q, out_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [31:0]       in_arr [NREQ];
  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [SW-1:0]     scan_sum;
  logic [IDW-1:0]    scan_idx;
  logic              accept;

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign in_arr[g] = in[32*g +: 32];
  end

  // Rotating-priority search: first asserted request at or after rr_ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SW'(k);
      if (scan_sum >= SW'(NREQ)) scan_sum = scan_sum - SW'(NREQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    out_d    = out_q;
    out_id_d = out_id_q;
    gnt_d    = '0;
    accept   = win_found && ((state_q == IDLE) || out_ready);
    if (accept) begin
      state_d  = HOLD;
      out_d    = (in_arr[win_idx] & SLICE_MSK) + PASSDOWN;
      out_id_d = win_idx;
      gnt_d    = NREQ'(1) << win_idx;
      rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      out_q    <= '0;
      out_id_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      out_id_q <= out_id_d;
      gnt_q    <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign out_id    = out_id_q;

`ifdef ADD_ARB_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if ((state_q == HOLD) && out_ready && (grant_cnt_q != 16'hFFFF))
      grant_cnt_d = grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_cnt_q <= '0;
    else     grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_add_arb.sv
// Bench for add_arb: three instances (N/PASSDOWN = 16/2, 2/1, 16/1) share stimulus and are checked
// every negedge against a transaction-level model, plus hand-computed literal expectations.
module tb_add_arb;

  localparam int NREQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] in_bus;
  logic               out_ready;

  logic [NREQ-1:0] gnt_a, gnt_b, gnt_c;
  logic            out_valid_a, out_valid_b, out_valid_c;
  logic [31:0]     out_a, out_b, out_c;
  logic [1:0]      out_id_a, out_id_b, out_id_c;
`ifdef ADD_ARB_STATS_EN
  logic [15:0]     grant_cnt_a, grant_cnt_b, grant_cnt_c;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: what the outputs must be, derived from the arbitration and arithmetic rules.
  logic            m_valid = 1'b0;
  logic [NREQ-1:0] m_gnt   = '0;
  int              m_ptr   = 0;
  int              m_id    = 0;
  logic [31:0]     m_out_a = '0;
  logic [31:0]     m_out_b = '0;
  logic [31:0]     m_out_c = '0;
  int              m_hs    = 0;

  always #5 clk = ~clk;

  add_arb #(.NREQ(NREQ), .N(16), .PASSDOWN(32'd2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .in(in_bus), .gnt(gnt_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out(out_a), .out_id(out_id_a)
`ifdef ADD_ARB_STATS_EN
    , .grant_cnt(grant_cnt_a)
`endif
  );

  add_arb #(.NREQ(NREQ), .N(2), .PASSDOWN(32'd1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .in(in_bus), .gnt(gnt_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out(out_b), .out_id(out_id_b)
`ifdef ADD_ARB_STATS_EN
    , .grant_cnt(grant_cnt_b)
`endif
  );

  add_arb #(.NREQ(NREQ), .N(16), .PASSDOWN(32'd1)) u_dut_c (
    .clk(clk), .rst(rst), .req(req), .in(in_bus), .gnt(gnt_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .out(out_c), .out_id(out_id_c)
`ifdef ADD_ARB_STATS_EN
    , .grant_cnt(grant_cnt_c)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] calc(input logic [31:0] w, input int nb, input longint unsigned p);
    longint unsigned s;
    s = (longint'(w) % (longint'(1) << nb)) + p;
    return s[31:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_gnt   = '0;
    m_ptr   = 0;
    m_id    = 0;
    m_out_a = '0;
    m_out_b = '0;
    m_out_c = '0;
    m_hs    = 0;
  endtask

  task automatic model_update();
    int          w;
    int          idx;
    logic [31:0] word;
    w = -1;
    if (m_valid && out_ready && m_hs < 65535) m_hs++;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req[idx]) w = idx;
      end
    end
    if (w >= 0) begin
      word    = in_bus[32*w +: 32];
      m_out_a = calc(word, 16, 2);
      m_out_b = calc(word, 2, 1);
      m_out_c = calc(word, 16, 1);
      m_gnt   = 4'(1 << w);
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % NREQ;
    end else begin
      m_gnt = '0;
      if (out_ready) m_valid = 1'b0;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, then inputs may change 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
  endtask

  task automatic set_in(input int i, input logic [31:0] v);
    in_bus[32*i +: 32] = v;
  endtask

  task automatic expect_a(input string name, input logic [3:0] g, input logic [1:0] id,
                          input logic v, input logic [31:0] o);
    check({name, ".gnt"},   32'(gnt_a),       32'(g));
    check({name, ".id"},    32'(out_id_a),    32'(id));
    check({name, ".valid"}, 32'(out_valid_a), 32'(v));
    check({name, ".out"},   out_a,            o);
  endtask

  // Per-cycle comparison of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc.valid_a", 32'(out_valid_a), 32'(m_valid));
      check("cyc.valid_b", 32'(out_valid_b), 32'(m_valid));
      check("cyc.valid_c", 32'(out_valid_c), 32'(m_valid));
      check("cyc.gnt_a",   32'(gnt_a),       32'(m_gnt));
      check("cyc.gnt_b",   32'(gnt_b),       32'(m_gnt));
      check("cyc.gnt_c",   32'(gnt_c),       32'(m_gnt));
      check("cyc.id_a",    32'(out_id_a),    32'(m_id));
      check("cyc.id_b",    32'(out_id_b),    32'(m_id));
      check("cyc.id_c",    32'(out_id_c),    32'(m_id));
      check("cyc.out_a",   out_a,            m_out_a);
      check("cyc.out_b",   out_b,            m_out_b);
      check("cyc.out_c",   out_c,            m_out_c);
`ifdef ADD_ARB_STATS_EN
      check("cyc.cnt_a",   32'(grant_cnt_a), 32'(m_hs));
`endif
    end
  end

  localparam logic [4:0] TAIL [16] = '{
    5'b10001, 5'b01100, 5'b01100, 5'b00001, 5'b11111, 5'b11110, 5'b00001, 5'b00000,
    5'b10101, 5'b01011, 5'b00011, 5'b00001, 5'b11001, 5'b00000, 5'b00001, 5'b00001
  };

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [4:0] tv;

  initial begin
    rst       = 1'b1;
    req       = '0;
    in_bus    = '0;
    out_ready = 1'b1;
    model_reset();
    step();
    step();
    expect_a("reset", 4'b0000, 2'd0, 1'b0, 32'h0);
    rst = 1'b0;

    // Round robin from rr_ptr = 0 with all requesters held; upper operand bits must be ignored.
    for (int i = 0; i < NREQ; i++) set_in(i, {16'hA5A0 + 16'(i), 16'h0010 + 16'(i)});
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      tv = 5'(i % 4);
      expect_a("rr", rr_exp[i], tv[1:0], 1'b1, 32'h12 + 32'(i % 4));
    end
    req = 4'b0000;
    step();
    expect_a("drain", 4'b0000, 2'd0, 1'b0, 32'h12);

    // Single request, small operand.
    set_in(0, 32'h0000_0005);
    req = 4'b0001;
    step();
    req = 4'b0000;
    expect_a("single", 4'b0001, 2'd0, 1'b1, 32'h7);
    step();

    // Slice boundaries and modulo behaviour across the three configurations.
    set_in(1, 32'hFFFF_FFFE);
    set_in(2, 32'hFFFF_FFFF);
    req = 4'b0010;
    step();
    expect_a("slice1", 4'b0010, 2'd1, 1'b1, 32'h0001_0000);
    check("slice1.b", out_b, 32'h3);
    check("slice1.c", out_c, 32'h0000_FFFF);
    req = 4'b0100;
    step();
    expect_a("slice2", 4'b0100, 2'd2, 1'b1, 32'h0001_0001);
    check("slice2.b", out_b, 32'h4);
    check("slice2.c", out_c, 32'h0001_0000);
    req = 4'b0000;
    step();

    // Back-pressure: result held five cycles while another requester waits.
    out_ready = 1'b0;
    req = 4'b0010;
    step();
    expect_a("hold.load", 4'b0010, 2'd1, 1'b1, 32'h0001_0000);
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_a("hold.stall", 4'b0000, 2'd1, 1'b1, 32'h0001_0000);
    end
    out_ready = 1'b1;
    step();
    req = 4'b0000;
    expect_a("hold.release", 4'b0100, 2'd2, 1'b1, 32'h0001_0001);
    step();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    req = 4'b0001;
    step();
    req = 4'b0000;
    check("pre_rst.valid", 32'(out_valid_a), 32'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    expect_a("async_rst", 4'b0000, 2'd0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    expect_a("post_rst", 4'b0000, 2'd0, 1'b0, 32'h0);
    req = 4'b1010;
    step();
    req = 4'b0000;
    expect_a("post_rst.acc", 4'b0010, 2'd1, 1'b1, 32'h0001_0000);
    step();

    // Mixed request / ready patterns, checked by the model only.
    for (int i = 0; i < NREQ; i++) set_in(i, 32'h1234_8000 + 32'(i * 32'h1111));
    for (int i = 0; i < 16; i++) begin
      tv        = TAIL[i];
      req       = tv[4:1];
      out_ready = tv[0];
      step();
    end
    req = 4'b0000;
    out_ready = 1'b1;
    step();
    step();

`ifdef ADD_ARB_STATS_EN
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
    end
    check("stats.three", 32'(grant_cnt_a), 32'd3);
    req = 4'b1111;
    repeat (65537) step();
    req = 4'b0000;
    check("stats.sat", 32'(grant_cnt_a), 32'h0000_FFFF);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
